// File: rtl/issue_hazard_unit.sv
// issue_hazard_unit: ID-stage read-after-write hazard detector for the
// 5-stage pipeline without forwarding. It tracks the destination registers
// of in-flight instructions and raises ST while an ID source register
// depends on the EX or MEM stage.
//
// Optional feature: define STALL_CNT_EN to build a saturating count of
// stall cycles on stall_cnt. When it is undefined, stall_cnt is tied to 0.
//
// The scoreboard is {wr, rd} per stage. Only EX and MEM are ever consulted
// because the register file writes in the first half of the cycle and reads
// in the second. For that reason an entry retires when it leaves MEM, and no
// WB copy is kept.

module issue_hazard_unit #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  output logic              ST,
  output logic              if_hold,
  output logic              hz_ex,
  output logic              hz_mem,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              wr;
    logic [REG_AW-1:0] rd;
  } sb_entry_t;

  sb_entry_t sb_ex;
  sb_entry_t sb_mem;

  logic use_rs1;
  logic use_rs2;
  logic id_writes;

  // Decode which source operands the ID opcode reads and whether it writes rd
  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    id_writes = 1'b0;
    case (id_opcode)
      4'b0000: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'b0001, 4'b0011, 4'b1111: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        id_writes = 1'b1;
      end
      4'b0111: begin
        use_rs1   = 1'b1;
        id_writes = 1'b1;
      end
      default: begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        id_writes = 1'b0;
      end
    endcase
  end

  // The hazard test is purely combinational so that ST is valid in the same cycle
  assign hz_ex  = id_valid & sb_ex.wr &
                  ((use_rs1 & (id_rs1 == sb_ex.rd)) | (use_rs2 & (id_rs2 == sb_ex.rd)));
  assign hz_mem = id_valid & sb_mem.wr &
                  ((use_rs1 & (id_rs1 == sb_mem.rd)) | (use_rs2 & (id_rs2 == sb_mem.rd)));

  assign ST      = hz_ex | hz_mem;
  assign if_hold = ST;

  // Advance the scoreboard; a stall or an empty ID slot injects a bubble into EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex  <= '0;
      sb_mem <= '0;
    end else if (flush) begin
      sb_ex  <= '0;
      sb_mem <= '0;
    end else begin
      sb_mem <= sb_ex;
      if (ST || !id_valid) begin
        sb_ex <= '0;
      end else begin
        sb_ex <= '{wr: id_writes, rd: id_rd};
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count stalled edges, excluding those that a flush discards, and saturate at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ST && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_hazard_unit.sv
// tb_issue_hazard_unit: directed and randomized checks of issue_hazard_unit
// against a behavioural model of in-flight writers kept by age.

module tb_issue_hazard_unit;

  localparam int AW       = 4;
  localparam int TB_CNT_W = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                id_valid = 1'b0;
  logic [3:0]          id_opcode = '0;
  logic [AW-1:0]       id_rd = '0;
  logic [AW-1:0]       id_rs1 = '0;
  logic [AW-1:0]       id_rs2 = '0;
  logic                flush = 1'b0;
  logic                st;
  logic                if_hold;
  logic                hz_ex;
  logic                hz_mem;
  logic [TB_CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model state: each in-flight writer with its age (0 = in EX, 1 = in MEM)
  typedef struct {
    int            age;
    logic [AW-1:0] rd;
  } inflight_t;

  inflight_t inflight[$];
  inflight_t next_q[$];
  int        stall_edges = 0;
  bit        model_st;

`ifdef STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  issue_hazard_unit #(
    .REG_AW (AW),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_rd     (id_rd),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .flush     (flush),
    .ST        (st),
    .if_hold   (if_hold),
    .hz_ex     (hz_ex),
    .hz_mem    (hz_mem),
    .stall_cnt (stall_cnt)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic bit reads_rs1(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd3) || (op == 4'd7) || (op == 4'd15);
  endfunction

  function automatic bit reads_rs2(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd3) || (op == 4'd15);
  endfunction

  function automatic bit writes_rd(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd3) || (op == 4'd7) || (op == 4'd15);
  endfunction

  // Does the ID instruction read a register written by an in-flight writer of this age?
  function automatic bit model_hz(input int age);
    if (!id_valid) return 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].age == age) begin
        if (reads_rs1(id_opcode) && (id_rs1 == inflight[i].rd)) return 1'b1;
        if (reads_rs2(id_opcode) && (id_rs2 == inflight[i].rd)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_cnt();
    int max_v;
    max_v = (1 << TB_CNT_W) - 1;
    if (!CNT_ON) return 0;
    return (stall_edges > max_v) ? max_v : stall_edges;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Age the model on each edge: writers move EX -> MEM -> retired, new issue enters EX
  always @(posedge clk) begin
    if (rst_n) begin
      model_st = model_hz(0) || model_hz(1);
      if (model_st && !flush) stall_edges++;
      if (flush) begin
        inflight.delete();
      end else begin
        next_q.delete();
        foreach (inflight[i]) begin
          if (inflight[i].age == 0) next_q.push_back('{age: 1, rd: inflight[i].rd});
        end
        if (id_valid && !model_st && writes_rd(id_opcode))
          next_q.push_back('{age: 0, rd: id_rd});
        inflight = next_q;
      end
    end
  end

  // Compare every output against the model in the middle of each cycle
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      cmp("model ST", int'(st), int'(model_hz(0) || model_hz(1)));
      cmp("model if_hold", int'(if_hold), int'(model_hz(0) || model_hz(1)));
      cmp("model hz_ex", int'(hz_ex), int'(model_hz(0)));
      cmp("model hz_mem", int'(hz_mem), int'(model_hz(1)));
      cmp("model stall_cnt", int'(stall_cnt), model_cnt());
    end
  end

  task automatic apply_stimulus(input bit v, input logic [3:0] op, input logic [AW-1:0] rd,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input bit fl);
    @(posedge clk);
    #2;
    id_valid  = v;
    id_opcode = op;
    id_rd     = rd;
    id_rs1    = rs1;
    id_rs2    = rs2;
    flush     = fl;
    #4;
  endtask

  task automatic check_output(input string tag, input bit e_st, input bit e_ex,
                              input bit e_mem, input int e_cnt);
    cmp({tag, " ST"}, int'(st), int'(e_st));
    cmp({tag, " if_hold"}, int'(if_hold), int'(e_st));
    cmp({tag, " hz_ex"}, int'(hz_ex), int'(e_ex));
    cmp({tag, " hz_mem"}, int'(hz_mem), int'(e_mem));
    cmp({tag, " stall_cnt"}, int'(stall_cnt), e_cnt);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    id_valid  = 1'b0;
    id_opcode = '0;
    id_rd     = '0;
    id_rs1    = '0;
    id_rs2    = '0;
    flush     = 1'b0;
    inflight.delete();
    stall_edges = 0;
    #1;
    check_output("reset", 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_on = 1'b1;
    apply_stimulus(1'b0, 4'd1, 4'd3, 4'd3, 4'd3, 1'b0);
    check_output("idle", 1'b0, 1'b0, 1'b0, 0);

    // EX dependence: two stall cycles, issue on the third edge
    do_reset();
    apply_stimulus(1'b1, 4'd1, 4'd3, 4'd0, 4'd0, 1'b0);
    check_output("ex_prod", 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 4'd3, 4'd6, 4'd3, 4'd1, 1'b0);
    check_output("ex_stall1", 1'b1, 1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 4'd3, 4'd6, 4'd3, 4'd1, 1'b0);
    check_output("ex_stall2", 1'b1, 1'b0, 1'b1, CNT_ON ? 1 : 0);
    apply_stimulus(1'b1, 4'd3, 4'd6, 4'd3, 4'd1, 1'b0);
    check_output("ex_issue", 1'b0, 1'b0, 1'b0, CNT_ON ? 2 : 0);

    // Asynchronous reset while stalled drops ST at once
    do_reset();
    apply_stimulus(1'b1, 4'd1, 4'd3, 4'd0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 4'd3, 4'd6, 4'd3, 4'd1, 1'b0);
    check_output("pre_rst", 1'b1, 1'b1, 1'b0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_rst", 1'b0, 1'b0, 1'b0, 0);
    do_reset();

    // MEM dependence: exactly one stall cycle
    apply_stimulus(1'b1, 4'd1, 4'd5, 4'd0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 4'd1, 4'd7, 4'd1, 4'd2, 1'b0);
    check_output("mem_indep", 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 4'd7, 4'd9, 4'd5, 4'd0, 1'b0);
    check_output("mem_stall", 1'b1, 1'b0, 1'b1, 0);
    apply_stimulus(1'b1, 4'd7, 4'd9, 4'd5, 4'd0, 1'b0);
    check_output("mem_issue", 1'b0, 1'b0, 1'b0, CNT_ON ? 1 : 0);

    // Store writes nothing; immediate ignores rs2
    do_reset();
    apply_stimulus(1'b1, 4'd0, 4'd9, 4'd1, 4'd2, 1'b0);
    apply_stimulus(1'b1, 4'd15, 4'd1, 4'd9, 4'd9, 1'b0);
    check_output("after_store", 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 4'd7, 4'd2, 4'd0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 4'd7, 4'd3, 4'd0, 4'd2, 1'b0);
    check_output("imm_rs2", 1'b0, 1'b0, 1'b0, 0);

    // Flush on the first stall cycle clears the scoreboard and is not counted
    do_reset();
    apply_stimulus(1'b1, 4'd1, 4'd4, 4'd0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 4'd1, 4'd8, 4'd4, 4'd0, 1'b1);
    check_output("flush_stall", 1'b1, 1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 4'd1, 4'd8, 4'd4, 4'd0, 1'b0);
    check_output("flush_after", 1'b0, 1'b0, 1'b0, 0);

    // NOP writes nothing; self-dependence is not a hazard
    do_reset();
    apply_stimulus(1'b1, 4'd5, 4'd6, 4'd0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 4'd1, 4'd7, 4'd6, 4'd6, 1'b0);
    check_output("after_nop", 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 4'd1, 4'd3, 4'd3, 4'd3, 1'b0);
    check_output("self_dep", 1'b0, 1'b0, 1'b0, 0);

    // EX and MEM both match: still a two-cycle stall
    do_reset();
    apply_stimulus(1'b1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 4'd3, 4'd2, 4'd0, 4'd1, 1'b0);
    check_output("both_indep", 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 4'd15, 4'd5, 4'd2, 4'd2, 1'b0);
    check_output("both1", 1'b1, 1'b1, 1'b1, 0);
    apply_stimulus(1'b1, 4'd15, 4'd5, 4'd2, 4'd2, 1'b0);
    check_output("both2", 1'b1, 1'b0, 1'b1, CNT_ON ? 1 : 0);
    apply_stimulus(1'b1, 4'd15, 4'd5, 4'd2, 4'd2, 1'b0);
    check_output("both_issue", 1'b0, 1'b0, 1'b0, CNT_ON ? 2 : 0);

    // Six stall cycles into a 2-bit counter must saturate at 3
    do_reset();
    for (int r = 0; r < 3; r++) begin
      apply_stimulus(1'b1, 4'd1, 4'd3, 4'd0, 4'd0, 1'b0);
      repeat (3) apply_stimulus(1'b1, 4'd3, 4'd6, 4'd3, 4'd1, 1'b0);
    end
    check_output("saturate", 1'b0, 1'b0, 1'b0, CNT_ON ? 3 : 0);

    // Randomized traffic with small register range to provoke dependences
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ((c != 0) && ($urandom_range(0, 1) == 0)) begin
        apply_stimulus(id_valid, id_opcode, id_rd, id_rs1, id_rs2,
                       ($urandom_range(0, 15) == 0));
      end else begin
        logic [3:0] op;
        if ($urandom_range(0, 1) == 0) begin
          case ($urandom_range(0, 3))
            0: op = 4'd1;
            1: op = 4'd3;
            2: op = 4'd7;
            default: op = 4'd15;
          endcase
        end else begin
          op = 4'($urandom_range(0, 15));
        end
        apply_stimulus(($urandom_range(0, 7) != 0), op,
                       AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                       AW'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      end
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
